load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 151 +++++++++++++++
 tb/tb_load_store_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word CPU accesses into word-wide data-memory
// cycles, with read-modify-write for sub-word stores and load extension.
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic        mem_store,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state_q, state_d;
    logic        store_q, store_d;
    logic [1:0]  size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        misaligned_q, misaligned_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic [4:0]  lane_shift;
    logic [31:0] lane_mask;
    logic [31:0] lane_data;
    logic [31:0] shifted_rdata;
    logic [31:0] merged_word;
    logic [31:0] load_word;
    logic        req_misaligned;

    // Lane selection from the latched address: merge for stores, extract+extend for loads.
    always_comb begin
        lane_shift    = {addr_q[1:0], 3'b000};
        shifted_rdata = mem_rdata >> lane_shift;
        lane_mask     = 32'hFFFF_FFFF;
        lane_data     = wdata_q;
        load_word     = mem_rdata;
        case (size_q)
            2'b00: begin
                lane_mask = 32'h0000_00FF << lane_shift;
                lane_data = {4{wdata_q[7:0]}};
                load_word = unsigned_q ? {24'h0, shifted_rdata[7:0]}
                                       : {{24{shifted_rdata[7]}}, shifted_rdata[7:0]};
            end
            2'b01: begin
                lane_mask = 32'h0000_FFFF << lane_shift;
                lane_data = {2{wdata_q[15:0]}};
                load_word = unsigned_q ? {16'h0, shifted_rdata[15:0]}
                                       : {{16{shifted_rdata[15]}}, shifted_rdata[15:0]};
            end
            default: ;
        endcase
        merged_word = (mem_rdata & ~lane_mask) | (lane_data & lane_mask);
    end

    always_comb begin
        case (req_size)
            2'b00:   req_misaligned = 1'b0;
            2'b01:   req_misaligned = req_addr[0];
            2'b10:   req_misaligned = (req_addr[1:0] != 2'b00);
            default: req_misaligned = 1'b1;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        store_d      = store_q;
        size_d       = size_q;
        unsigned_d   = unsigned_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        misaligned_d = misaligned_q;
        resp_rdata_d = resp_rdata_q;
        mem_wdata_d  = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    store_d      = req_store;
                    size_d       = req_size;
                    unsigned_d   = req_unsigned;
                    addr_d       = req_addr;
                    wdata_d      = req_wdata;
                    misaligned_d = req_misaligned;
                    if (req_misaligned) begin
                        state_d = RESP;
                    end else if (req_store && req_size == 2'b10) begin
                        mem_wdata_d = req_wdata;
                        state_d     = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                if (store_q) begin
                    mem_wdata_d = merged_word;
                    state_d     = WRITE;
                end else begin
                    resp_rdata_d = load_word;
                    state_d      = RESP;
                end
            end
            WRITE:   state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            store_q      <= 1'b0;
            size_q       <= 2'b00;
            unsigned_q   <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            misaligned_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            mem_wdata_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            store_q      <= store_d;
            size_q       <= size_d;
            unsigned_q   <= unsigned_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            misaligned_q <= misaligned_d;
            resp_rdata_q <= resp_rdata_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign req_ready       = (state_q == IDLE);
    assign resp_valid      = (state_q == RESP);
    assign resp_misaligned = (state_q == RESP) && misaligned_q;
    assign resp_rdata      = resp_rdata_q;
    assign mem_store       = (state_q == WRITE);
    assign mem_addr        = {2'b00, addr_q[31:2]};
    assign mem_wdata       = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: directed and random accesses against a byte-level
// reference model of memory and of the access latencies.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic        mem_store;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem  [16];
    logic [31:0] gold [16];
    logic [31:0] last_rdata = 32'h0;
    int total = 0;
    int bad = 0;

    load_store_unit dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_store(req_store), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_misaligned(resp_misaligned),
        .mem_store(mem_store), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Data memory: combinational read, write on the rising edge when mem_store is high.
    assign mem_rdata = mem[mem_addr[3:0]];
    always @(posedge clk) if (mem_store) mem[mem_addr[3:0]] <= mem_wdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input int idx, input logic [31:0] w);
        mem[idx]  = w;
        gold[idx] = w;
    endtask

    // One complete access; expectations come from byte arithmetic on the gold memory.
    task automatic do_access(input logic st, input logic [1:0] sz, input logic uns,
                             input logic [31:0] a, input logic [31:0] wd);
        logic [7:0]  b [4];
        logic [31:0] exp_rdata, exp_word, val;
        int idx, off, exp_resp_cyc, exp_store_cyc, resp_cyc, store_cyc, nresp, nstore;
        logic mis;
        idx = int'(a[5:2]);
        off = int'(a[1:0]);
        mis = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        for (int k = 0; k < 4; k++) b[k] = gold[idx][8*k +: 8];
        exp_rdata = last_rdata;
        exp_word  = gold[idx];
        if (mis) begin
            exp_resp_cyc = 1; exp_store_cyc = 0;
        end else if (!st) begin
            exp_resp_cyc = 2; exp_store_cyc = 0;
            if (sz == 2'b00) begin
                val = 32'(b[off]);
                exp_rdata = (!uns && val >= 128) ? val + 32'hFFFF_FF00 : val;
            end else if (sz == 2'b01) begin
                val = 32'(b[off]) + 256 * 32'(b[off+1]);
                exp_rdata = (!uns && val >= 32768) ? val + 32'hFFFF_0000 : val;
            end else begin
                exp_rdata = gold[idx];
            end
        end else begin
            if (sz == 2'b10) begin
                exp_resp_cyc = 2; exp_store_cyc = 1; exp_word = wd;
            end else begin
                exp_resp_cyc = 3; exp_store_cyc = 2;
                b[off] = wd[7:0];
                if (sz == 2'b01) b[off+1] = wd[15:8];
                exp_word = {b[3], b[2], b[1], b[0]};
            end
        end

        @(negedge clk);
        check("ready_before", {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_store = st; req_size = sz;
        req_unsigned = uns; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_store = ~st; req_size = $urandom_range(0, 3);
        req_unsigned = ~uns; req_addr = $urandom; req_wdata = $urandom;

        resp_cyc = 0; store_cyc = 0; nresp = 0; nstore = 0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            if (mem_store) begin
                nstore++; store_cyc = cyc;
                check("mem_addr", mem_addr, 32'(idx));
                check("mem_wdata", mem_wdata, exp_word);
            end
            if (resp_valid) begin
                nresp++; resp_cyc = cyc;
                check("resp_misaligned", {31'h0, resp_misaligned}, {31'h0, mis});
                check("resp_rdata", resp_rdata, exp_rdata);
            end
        end
        check("resp_cycle", 32'(resp_cyc), 32'(exp_resp_cyc));
        check("resp_count", 32'(nresp), 32'h1);
        check("store_cycle", 32'(store_cyc), 32'(exp_store_cyc));
        check("store_count", 32'(nstore), (exp_store_cyc != 0) ? 32'h1 : 32'h0);
        if (st && !mis) gold[idx] = exp_word;
        last_rdata = exp_rdata;
        check("mem_word", mem[idx], gold[idx]);
    endtask

    initial begin
        logic [31:0] exp_a, exp_b;
        int resp_seen;
        $display("[TB] start");
        for (int i = 0; i < 16; i++) set_word(i, $urandom);

        // Reset, with a request pending that must be ignored.
        req_valid = 1'b1; req_addr = 32'h4;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'h0, req_ready}, 32'h1);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_misaligned", {31'h0, resp_misaligned}, 32'h0);
        check("rst_mem_store", {31'h0, mem_store}, 32'h0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_idle", {31'h0, req_ready}, 32'h1);

        // Directed cases.
        set_word(1, 32'h0000_8610);
        do_access(1'b0, 2'b00, 1'b0, 32'h5, 32'h0);
        check("lb_value", last_rdata, 32'hFFFF_FF86);
        do_access(1'b0, 2'b00, 1'b1, 32'h5, 32'h0);
        check("lbu_value", last_rdata, 32'h0000_0086);
        set_word(0, 32'h0000_4430);
        do_access(1'b1, 2'b01, 1'b0, 32'h2, 32'h0000_BEEF);
        check("sh_word", gold[0], 32'hBEEF_4430);
        do_access(1'b1, 2'b10, 1'b0, 32'hC, 32'hDEAD_BEEF);
        do_access(1'b0, 2'b10, 1'b0, 32'h6, 32'h0);
        do_access(1'b1, 2'b11, 1'b0, 32'h8, 32'h1234_5678);
        do_access(1'b0, 2'b01, 1'b0, 32'h3, 32'h0);

        // Store aborted by reset while reading.
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_size = 2'b00; req_addr = 32'h9; req_wdata = 32'hAA;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        last_rdata = 32'h0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            check("abort_mem_store", {31'h0, mem_store}, 32'h0);
            check("abort_resp_valid", {31'h0, resp_valid}, 32'h0);
        end
        check("abort_ready", {31'h0, req_ready}, 32'h1);
        check("abort_mem", mem[2], gold[2]);

        // Two loads with req_valid held high.
        exp_a = gold[4];
        exp_b = gold[5];
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h10;
        @(posedge clk);
        #1;
        req_addr = 32'h14;
        resp_seen = 0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            check("b2b_no_store", {31'h0, mem_store}, 32'h0);
            if (resp_valid) begin
                resp_seen++;
                check("b2b_cycle", 32'(cyc), (resp_seen == 1) ? 32'd2 : 32'd5);
                check("b2b_rdata", resp_rdata, (resp_seen == 1) ? exp_a : exp_b);
            end
            if (cyc == 3) begin
                check("b2b_ready", {31'h0, req_ready}, 32'h1);
                @(posedge clk);
                #1;
                req_valid = 1'b0;
            end
        end
        check("b2b_count", 32'(resp_seen), 32'd2);
        last_rdata = exp_b;

        // Random accesses.
        for (int n = 0; n < 80; n++) begin
            do_access(1'($urandom_range(0, 1)),
                      ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
                      1'($urandom_range(0, 1)),
                      32'($urandom_range(0, 63)), $urandom);
        end
        for (int i = 0; i < 16; i++) check("final_mem", mem[i], gold[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
